// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side controller between the uart_rx deserializer and a
// byte consumer. It captures each finished frame, acknowledges it with a one-cycle
// rx_accept pulse, and pushes clean bytes into a first-word-fall-through FIFO. It
// also keeps saturating parity, framing and overrun counters.
//
// Ports:
//   clk, rst_n            clock; asynchronous reset, active-high (reset while rst_n=1)
//   rx_done/rx_data       frame-done level and byte from uart_rx
//   rx_parity_err         parity error flag from uart_rx
//   rx_framing_err        framing error flag from uart_rx
//   rx_accept             one-cycle registered acknowledge back to uart_rx
//   m_valid/m_data        FIFO head; popped when m_valid && m_ready
//   m_err                 {framing, parity} of the head entry (UART_RX_CTRL_KEEP_ERR_EN only)
//   level                 FIFO occupancy
//   overflow              sticky overrun indication
//   parity_cnt, framing_cnt, overrun_cnt   saturating event counters
//   clr_stats             synchronous clear of counters and overflow
//
// Build option: define UART_RX_CTRL_KEEP_ERR_EN to keep errored frames in the FIFO
// (10-bit entries, m_err port present) instead of discarding them.

module uart_rx_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_done,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_parity_err,
  input  logic                          rx_framing_err,
  output logic                          rx_accept,
  output logic                          m_valid,
  output logic [7:0]                    m_data,
`ifdef UART_RX_CTRL_KEEP_ERR_EN
  output logic [1:0]                    m_err,
`endif
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic [CNT_WIDTH-1:0]          parity_cnt,
  output logic [CNT_WIDTH-1:0]          framing_cnt,
  output logic [CNT_WIDTH-1:0]          overrun_cnt,
  input  logic                          clr_stats
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
`ifdef UART_RX_CTRL_KEEP_ERR_EN
  localparam int EW = 10;
`else
  localparam int EW = 8;
`endif

  localparam logic [LW-1:0]        LVL_ONE  = LW'(1);
  localparam logic [LW-1:0]        LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [AW-1:0]        PTR_ONE  = AW'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DECIDE   = 2'd1,
    ACK      = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Latched frame
  logic [7:0] lat_data;
  logic       lat_par;
  logic       lat_frm;

  // FIFO storage; entry layout is {framing, parity, data} when flags are kept
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] head_idx;
  logic [EW-1:0] head_entry;
  logic [EW-1:0] push_entry;

  logic full;
  logic pop;
  logic push;
  logic drop_err;
  logic inc_par;
  logic inc_frm;
  logic inc_ovr;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (rx_done) state_d = DECIDE;
      DECIDE:   state_d = ACK;
      ACK:      state_d = WAIT_LOW;
      WAIT_LOW: if (!rx_done) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Frame latch and registered acknowledge. rx_accept is high exactly while in ACK.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      lat_data  <= '0;
      lat_par   <= 1'b0;
      lat_frm   <= 1'b0;
      rx_accept <= 1'b0;
    end else begin
      if (state_q == IDLE && rx_done) begin
        lat_data <= rx_data;
        lat_par  <= rx_parity_err;
        lat_frm  <= rx_framing_err;
      end
      rx_accept <= (state_q == DECIDE);
    end
  end

  // ---------------- Classification ----------------
  assign full = (level == LVL_FULL);
  // m_valid is a pure function of the level register, so m_ready never reaches it.
  assign pop  = m_valid && m_ready;

  always_comb begin
    drop_err = 1'b0;
    push     = 1'b0;
    inc_par  = 1'b0;
    inc_frm  = 1'b0;
    inc_ovr  = 1'b0;
`ifndef UART_RX_CTRL_KEEP_ERR_EN
    drop_err = lat_par || lat_frm;
`endif
    if (state_q == DECIDE) begin
      inc_par = lat_par;
      inc_frm = lat_frm;
      if (!drop_err) begin
        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        if (full && !pop) inc_ovr = 1'b1;
        else              push    = 1'b1;
      end
    end
  end

`ifdef UART_RX_CTRL_KEEP_ERR_EN
  assign push_entry = {lat_frm, lat_par, lat_data};
`else
  assign push_entry = lat_data;
`endif

  // ---------------- FIFO ----------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  assign m_valid = (level != '0);

  // While empty, show the most recently popped slot so the head outputs hold
  // their last value. That slot cannot be written until the FIFO is non-empty,
  // since the next write goes to rd_ptr. After reset it reads the cleared array.
  assign head_idx   = m_valid ? rd_ptr : (rd_ptr - PTR_ONE);
  assign head_entry = mem[head_idx];
  assign m_data     = head_entry[7:0];
`ifdef UART_RX_CTRL_KEEP_ERR_EN
  assign m_err      = head_entry[9:8];
`endif

  // ---------------- Statistics ----------------
  // clr_stats wins over a same-edge event; counters stick at all-ones.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      parity_cnt  <= '0;
      framing_cnt <= '0;
      overrun_cnt <= '0;
      overflow    <= 1'b0;
    end else if (clr_stats) begin
      parity_cnt  <= '0;
      framing_cnt <= '0;
      overrun_cnt <= '0;
      overflow    <= 1'b0;
    end else begin
      if (inc_par && parity_cnt  != '1) parity_cnt  <= parity_cnt  + CNT_ONE;
      if (inc_frm && framing_cnt != '1) framing_cnt <= framing_cnt + CNT_ONE;
      if (inc_ovr && overrun_cnt != '1) overrun_cnt <= overrun_cnt + CNT_ONE;
      if (inc_ovr) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  logic       clk;
  logic       rst_n;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       rx_parity_err;
  logic       rx_framing_err;
  logic       rx_accept;
  logic       m_valid;
  logic [7:0] m_data;
`ifdef UART_RX_CTRL_KEEP_ERR_EN
  logic [1:0] m_err;
`endif
  logic       m_ready;
  logic [3:0] level;
  logic       overflow;
  logic [7:0] parity_cnt;
  logic [7:0] framing_cnt;
  logic [7:0] overrun_cnt;
  logic       clr_stats;

  int checks = 0;
  int errors = 0;

  uart_rx_ctrl #(.FIFO_DEPTH(8), .CNT_WIDTH(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_done        (rx_done),
    .rx_data        (rx_data),
    .rx_parity_err  (rx_parity_err),
    .rx_framing_err (rx_framing_err),
    .rx_accept      (rx_accept),
    .m_valid        (m_valid),
    .m_data         (m_data),
`ifdef UART_RX_CTRL_KEEP_ERR_EN
    .m_err          (m_err),
`endif
    .m_ready        (m_ready),
    .level          (level),
    .overflow       (overflow),
    .parity_cnt     (parity_cnt),
    .framing_cnt    (framing_cnt),
    .overrun_cnt    (overrun_cnt),
    .clr_stats      (clr_stats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All frame tasks start and end just after a falling edge.
  // Raise rx_done; after E0 the acknowledge must still be low.
  task automatic to_e0(input logic [7:0] d, input logic p, input logic f);
    rx_data        = d;
    rx_parity_err  = p;
    rx_framing_err = f;
    rx_done        = 1'b1;
    @(negedge clk);
    chk("accept_after_e0", rx_accept, 1'b0);
  endtask

  // After E1 the acknowledge is high.
  task automatic to_e1();
    @(negedge clk);
    chk("accept_after_e1", rx_accept, 1'b1);
  endtask

  // Release rx_done; the pulse ends at E2, WAIT_LOW returns to IDLE at E3.
  task automatic finish_frame();
    rx_done = 1'b0;
    @(negedge clk);
    chk("accept_after_e2", rx_accept, 1'b0);
    @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] d, input logic p, input logic f);
    to_e0(d, p, f);
    to_e1();
    finish_frame();
  endtask

  logic [7:0] drain_exp [8];

  initial begin
    rst_n          = 1'b1;
    rx_done        = 1'b0;
    rx_data        = 8'h00;
    rx_parity_err  = 1'b0;
    rx_framing_err = 1'b0;
    m_ready        = 1'b0;
    clr_stats      = 1'b0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_accept",   rx_accept,   1'b0);
    chk("rst_m_valid",  m_valid,     1'b0);
    chk("rst_m_data",   m_data,      8'h00);
    chk("rst_level",    level,       4'd0);
    chk("rst_overflow", overflow,    1'b0);
    chk("rst_parity",   parity_cnt,  8'd0);
    chk("rst_framing",  framing_cnt, 8'd0);
    chk("rst_overrun",  overrun_cnt, 8'd0);
`ifdef UART_RX_CTRL_KEEP_ERR_EN
    chk("rst_m_err",    m_err,       2'b00);
`endif
    rst_n = 1'b0;
    @(negedge clk);

    // ---- good frame, consumer ready ----
    m_ready = 1'b1;
    to_e0(8'h5A, 1'b0, 1'b0);
    chk("good_valid_before_e1", m_valid, 1'b0);
    to_e1();
    chk("good_valid", m_valid, 1'b1);
    chk("good_data",  m_data,  8'h5A);
    chk("good_level", level,   4'd1);
    finish_frame();
    chk("good_valid_after_pop", m_valid, 1'b0);
    chk("good_data_hold",       m_data,  8'h5A);
    chk("good_parity_cnt",      parity_cnt,  8'd0);
    chk("good_framing_cnt",     framing_cnt, 8'd0);
    chk("good_overrun_cnt",     overrun_cnt, 8'd0);

    // ---- parity-errored frame ----
    to_e0(8'hA5, 1'b1, 1'b0);
    to_e1();
    chk("par_cnt", parity_cnt, 8'd1);
`ifdef UART_RX_CTRL_KEEP_ERR_EN
    chk("par_valid", m_valid, 1'b1);
    chk("par_data",  m_data,  8'hA5);
    chk("par_err",   m_err,   2'b01);
`else
    chk("par_valid", m_valid, 1'b0);
    chk("par_level", level,   4'd0);
    chk("par_data_hold", m_data, 8'h5A);
`endif
    finish_frame();

    // ---- clear, then frame with both flags ----
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    chk("clr_parity", parity_cnt, 8'd0);
    to_e0(8'h3C, 1'b1, 1'b1);
    to_e1();
    chk("both_parity",  parity_cnt,  8'd1);
    chk("both_framing", framing_cnt, 8'd1);
`ifdef UART_RX_CTRL_KEEP_ERR_EN
    chk("both_err", m_err, 2'b11);
`endif
    finish_frame();
    chk("both_framing_stable", framing_cnt, 8'd1);

    // ---- fill past capacity with consumer stalled ----
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) frame(8'(i), 1'b0, 1'b0);
    chk("fill_level",    level,       4'd8);
    chk("fill_overrun",  overrun_cnt, 8'd2);
    chk("fill_overflow", overflow,    1'b1);
    chk("fill_head",     m_data,      8'h00);
    chk("fill_valid",    m_valid,     1'b1);

    // ---- full FIFO, pop coincident with the DECIDE edge ----
    to_e0(8'hAA, 1'b0, 1'b0);
    m_ready = 1'b1;
    to_e1();
    m_ready = 1'b0;
    chk("fullpop_level",   level,       4'd8);
    chk("fullpop_overrun", overrun_cnt, 8'd2);
    chk("fullpop_head",    m_data,      8'h01);
    finish_frame();

    // ---- drain ----
    for (int i = 0; i < 7; i++) drain_exp[i] = 8'(i + 1);
    drain_exp[7] = 8'hAA;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", m_valid, 1'b1);
      chk("drain_data",  m_data,  drain_exp[i]);
      @(negedge clk);
    end
    chk("drain_empty",     m_valid, 1'b0);
    chk("drain_level",     level,   4'd0);
    chk("drain_data_hold", m_data,  8'hAA);

    // ---- saturate parity counter (currently 1) ----
    for (int i = 0; i < 254; i++) frame(8'h77, 1'b1, 1'b0);
    chk("sat_parity_255", parity_cnt, 8'd255);
    frame(8'h78, 1'b1, 1'b0);
    chk("sat_parity_hold", parity_cnt, 8'd255);
    chk("sat_overflow_kept", overflow, 1'b1);

    // ---- clr_stats coincident with an error event ----
    to_e0(8'h55, 1'b1, 1'b0);
    clr_stats = 1'b1;
    to_e1();
    clr_stats = 1'b0;
    chk("clr_coinc_parity",   parity_cnt,  8'd0);
    chk("clr_coinc_overflow", overflow,    1'b0);
    chk("clr_coinc_framing",  framing_cnt, 8'd0);
    chk("clr_coinc_overrun",  overrun_cnt, 8'd0);
    finish_frame();
    frame(8'h56, 1'b1, 1'b0);
    chk("after_clr_parity", parity_cnt, 8'd1);

    // ---- reset during WAIT_LOW with rx_done held ----
    m_ready = 1'b0;
    to_e0(8'h11, 1'b0, 1'b0);
    to_e1();
    @(negedge clk);
    chk("wl_accept_low", rx_accept, 1'b0);
    chk("wl_level",      level,     4'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("wl_rst_level",  level,     4'd0);
    chk("wl_rst_valid",  m_valid,   1'b0);
    chk("wl_rst_data",   m_data,    8'h00);
    chk("wl_rst_accept", rx_accept, 1'b0);
    rst_n = 1'b0;
    to_e0(8'h11, 1'b0, 1'b0);
    to_e1();
    chk("recap_level", level,   4'd1);
    chk("recap_valid", m_valid, 1'b1);
    chk("recap_data",  m_data,  8'h11);
    finish_frame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
